// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the instruction/data cache memory-port arbiter.
package mem_port_arbiter_pkg;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] I_GNT = 2'b01;
  localparam logic [1:0] D_GNT = 2'b10;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_I_GNT = I_GNT,
    ST_D_GNT = D_GNT
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the icache
// and the dcache; the granted cache's request is muxed onto the memory bus.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 28,
  parameter int LINE_W  = 128,
  parameter int D_FIRST = 1,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic [LINE_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  cnt_i_grant,
  output logic [CNT_W-1:0]  cnt_d_grant,
  output logic [CNT_W-1:0]  cnt_conflict,
  output logic [1:0]        dbg_state
);

  // Handshake: a cache holds its request level-high until it sees a one-cycle
  // *_ready pulse; dropping the request earlier abandons the transfer.
  arb_state_e state;
  logic       rr_last;
  logic       i_req;
  logic       d_req;
  logic       grant_i;
  logic       grant_d;
  logic       conflict;

  assign i_req     = i_mem_read;
  assign d_req     = d_mem_read | d_mem_write;
  assign dbg_state = state;

  // On a tie the cache that did not win last time takes the port.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == ST_IDLE) begin
      if (i_req && d_req) begin
        grant_d = (rr_last == REQ_I);
        grant_i = (rr_last == REQ_D);
      end else begin
        grant_i = i_req;
        grant_d = d_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!proc_reset_n) begin
      state   <= ST_IDLE;
      rr_last <= (D_FIRST != 0) ? REQ_I : REQ_D;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_i) begin
            state   <= ST_I_GNT;
            rr_last <= REQ_I;
          end else if (grant_d) begin
            state   <= ST_D_GNT;
            rr_last <= REQ_D;
          end
        end
        ST_I_GNT: if (mem_ready || !i_req) state <= ST_IDLE;
        ST_D_GNT: if (mem_ready || !d_req) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // A ready arriving while reset is asserted is swallowed.
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    i_mem_ready = 1'b0;
    d_mem_ready = 1'b0;
    case (state)
      ST_I_GNT: begin
        mem_read    = i_mem_read;
        mem_addr    = i_mem_addr;
        i_mem_ready = mem_ready & proc_reset_n;
      end
      ST_D_GNT: begin
        mem_read    = d_mem_read;
        mem_write   = d_mem_write;
        mem_addr    = d_mem_addr;
        mem_wdata   = d_mem_wdata;
        d_mem_ready = mem_ready & proc_reset_n;
      end
      default: ;
    endcase
  end

  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;
  assign conflict    = ((state == ST_I_GNT) && d_req) || ((state == ST_D_GNT) && i_req);

  sat_counter #(.CNT_W(CNT_W)) u_cnt_i (
    .clk(clk), .clear_n(proc_reset_n), .inc(grant_i), .count(cnt_i_grant)
  );
  sat_counter #(.CNT_W(CNT_W)) u_cnt_d (
    .clk(clk), .clear_n(proc_reset_n), .inc(grant_d), .count(cnt_d_grant)
  );
  sat_counter #(.CNT_W(CNT_W)) u_cnt_c (
    .clk(clk), .clear_n(proc_reset_n), .inc(conflict), .count(cnt_conflict)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle table, contention, abort, reset and saturation.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int ADDR_W = 28;
  localparam int LINE_W = 128;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic proc_reset_n;

  logic              i_mem_read, d_mem_read, d_mem_write, mem_ready;
  logic [ADDR_W-1:0] i_mem_addr, d_mem_addr;
  logic [LINE_W-1:0] d_mem_wdata, mem_rdata;
  logic [LINE_W-1:0] i_mem_rdata, d_mem_rdata, mem_wdata;
  logic              i_mem_ready, d_mem_ready, mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       cnt_i_grant, cnt_d_grant, cnt_conflict;
  logic [1:0]        dbg_state;

  logic [LINE_W-1:0] s_i_rdata, s_d_rdata, s_wdata;
  logic              s_i_ready, s_d_ready, s_read, s_write;
  logic [ADDR_W-1:0] s_addr;
  logic [3:0]        s_cnt_i, s_cnt_d, s_cnt_c;
  logic [1:0]        s_state;

  mem_port_arbiter dut (
    .clk(clk), .proc_reset_n(proc_reset_n),
    .i_mem_read(i_mem_read), .i_mem_addr(i_mem_addr), .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata),
    .d_mem_rdata(d_mem_rdata), .d_mem_ready(d_mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .cnt_i_grant(cnt_i_grant), .cnt_d_grant(cnt_d_grant), .cnt_conflict(cnt_conflict), .dbg_state(dbg_state)
  );

  mem_port_arbiter #(.CNT_W(4)) dut_s (
    .clk(clk), .proc_reset_n(proc_reset_n),
    .i_mem_read(i_mem_read), .i_mem_addr(i_mem_addr), .i_mem_rdata(s_i_rdata), .i_mem_ready(s_i_ready),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata),
    .d_mem_rdata(s_d_rdata), .d_mem_ready(s_d_ready),
    .mem_read(s_read), .mem_write(s_write), .mem_addr(s_addr), .mem_wdata(s_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .cnt_i_grant(s_cnt_i), .cnt_d_grant(s_cnt_d), .cnt_conflict(s_cnt_c), .dbg_state(s_state)
  );

  // scoreboard
  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk)
    if (d_mem_read && d_mem_write) $error("dcache drove read and write together");

  always @(negedge clk) begin
    #2;
    if (proc_reset_n === 1'b1) begin
      check("excl_ready", {127'd0, i_mem_ready & d_mem_ready}, '0);
      check("excl_rw", {127'd0, mem_read & mem_write}, '0);
    end
  end

  typedef struct {
    logic        rst_n, i_rd, d_rd, d_wr, mrdy;
    logic [27:0] ia;
    logic [1:0]  st;
    logic        m_rd, m_wr;
    logic [27:0] ma;
    logic        ws, i_rdy, d_rdy;
    int          ci, cd, cc;
  } vec_t;

  function automatic vec_t mk(logic rst_n, logic i_rd, logic d_rd, logic d_wr, logic mrdy, logic [27:0] ia,
                              logic [1:0] st, logic m_rd, logic m_wr, logic [27:0] ma, logic ws,
                              logic i_rdy, logic d_rdy, int ci, int cd, int cc);
    vec_t v;
    v.rst_n = rst_n; v.i_rd = i_rd; v.d_rd = d_rd; v.d_wr = d_wr; v.mrdy = mrdy; v.ia = ia;
    v.st = st; v.m_rd = m_rd; v.m_wr = m_wr; v.ma = ma; v.ws = ws;
    v.i_rdy = i_rdy; v.d_rdy = d_rdy; v.ci = ci; v.cd = cd; v.cc = cc;
    return v;
  endfunction

  localparam logic [LINE_W-1:0] WD = 128'hC0DE_0001_2345_6789_ABCD_EF01_F00D_BEEF;
  localparam logic [27:0] D_ADDR = 28'h0000100;

  vec_t vecs[22];
  logic exp_id;
  int   k;

  initial begin
    proc_reset_n = 1'b0;
    i_mem_read = 1'b0; d_mem_read = 1'b0; d_mem_write = 1'b0; mem_ready = 1'b0;
    i_mem_addr = '0; d_mem_addr = D_ADDR; d_mem_wdata = WD; mem_rdata = '0;
    repeat (2) @(posedge clk);

    //              rst i d w rdy ia           st     rd wr ma       ws ir dr ci cd cc
    vecs[0]  = mk(0, 0, 0, 0, 0, 28'h0,   IDLE,  0, 0, 28'h0,   0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 1, 0, 0, 0, 28'h40,  IDLE,  0, 0, 28'h0,   0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 1, 0, 0, 0, 28'h40,  I_GNT, 1, 0, 28'h40,  0, 0, 0, 1, 0, 0);
    vecs[3]  = mk(1, 1, 0, 0, 0, 28'h40,  I_GNT, 1, 0, 28'h40,  0, 0, 0, 1, 0, 0);
    vecs[4]  = mk(1, 1, 0, 0, 1, 28'h40,  I_GNT, 1, 0, 28'h40,  0, 1, 0, 1, 0, 0);
    vecs[5]  = mk(1, 0, 0, 0, 1, 28'h40,  IDLE,  0, 0, 28'h0,   0, 0, 0, 1, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 0, 28'h0,   IDLE,  0, 0, 28'h0,   0, 0, 0, 1, 0, 0);
    vecs[7]  = mk(1, 1, 0, 1, 0, 28'h200, IDLE,  0, 0, 28'h0,   0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(1, 1, 0, 1, 0, 28'h200, D_GNT, 0, 1, D_ADDR,  1, 0, 0, 0, 1, 0);
    vecs[9]  = mk(1, 1, 0, 1, 0, 28'h200, D_GNT, 0, 1, D_ADDR,  1, 0, 0, 0, 1, 1);
    vecs[10] = mk(1, 1, 0, 1, 1, 28'h200, D_GNT, 0, 1, D_ADDR,  1, 0, 1, 0, 1, 2);
    vecs[11] = mk(1, 1, 0, 0, 0, 28'h200, IDLE,  0, 0, 28'h0,   0, 0, 0, 0, 1, 3);
    vecs[12] = mk(1, 1, 0, 0, 0, 28'h200, I_GNT, 1, 0, 28'h200, 0, 0, 0, 1, 1, 3);
    vecs[13] = mk(1, 1, 0, 0, 1, 28'h200, I_GNT, 1, 0, 28'h200, 0, 1, 0, 1, 1, 3);
    vecs[14] = mk(1, 0, 0, 0, 0, 28'h200, IDLE,  0, 0, 28'h0,   0, 0, 0, 1, 1, 3);
    vecs[15] = mk(1, 1, 0, 0, 0, 28'h40,  IDLE,  0, 0, 28'h0,   0, 0, 0, 1, 1, 3);
    vecs[16] = mk(1, 1, 1, 0, 0, 28'h40,  I_GNT, 1, 0, 28'h40,  0, 0, 0, 2, 1, 3);
    vecs[17] = mk(1, 0, 1, 0, 0, 28'h40,  I_GNT, 0, 0, 28'h40,  0, 0, 0, 2, 1, 4);
    vecs[18] = mk(1, 0, 1, 0, 0, 28'h40,  IDLE,  0, 0, 28'h0,   0, 0, 0, 2, 1, 5);
    vecs[19] = mk(1, 0, 1, 0, 0, 28'h40,  D_GNT, 1, 0, D_ADDR,  1, 0, 0, 2, 2, 5);
    vecs[20] = mk(0, 0, 1, 0, 1, 28'h40,  D_GNT, 1, 0, D_ADDR,  1, 0, 0, 2, 2, 5);
    vecs[21] = mk(1, 0, 0, 0, 0, 28'h0,   IDLE,  0, 0, 28'h0,   0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      proc_reset_n = vecs[i].rst_n; i_mem_read = vecs[i].i_rd; d_mem_read = vecs[i].d_rd;
      d_mem_write = vecs[i].d_wr; mem_ready = vecs[i].mrdy; i_mem_addr = vecs[i].ia;
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      #1;
      check($sformatf("r%0d_state", i), dbg_state, vecs[i].st);
      check($sformatf("r%0d_mem_read", i), mem_read, vecs[i].m_rd);
      check($sformatf("r%0d_mem_write", i), mem_write, vecs[i].m_wr);
      check($sformatf("r%0d_mem_addr", i), mem_addr, vecs[i].ma);
      check($sformatf("r%0d_mem_wdata", i), mem_wdata, vecs[i].ws ? WD : '0);
      check($sformatf("r%0d_i_ready", i), i_mem_ready, vecs[i].i_rdy);
      check($sformatf("r%0d_d_ready", i), d_mem_ready, vecs[i].d_rdy);
      check($sformatf("r%0d_i_rdata", i), i_mem_rdata, mem_rdata);
      check($sformatf("r%0d_d_rdata", i), d_mem_rdata, mem_rdata);
      check($sformatf("r%0d_cnt_i", i), cnt_i_grant, vecs[i].ci);
      check($sformatf("r%0d_cnt_d", i), cnt_d_grant, vecs[i].cd);
      check($sformatf("r%0d_cnt_c", i), cnt_conflict, vecs[i].cc);
    end

    // continuous contention: both held, grants must alternate D, I, D, ...
    @(negedge clk);
    i_mem_read = 1'b1; i_mem_addr = 28'h200; d_mem_read = 1'b1; mem_ready = 1'b0;
    exp_id = REQ_D;
    for (int t = 0; t < 10; t++) begin
      k = 0;
      while (dbg_state == IDLE && k < 6) begin
        @(negedge clk); mem_ready = 1'b0; #1; k++;
      end
      check($sformatf("cont%0d_grant", t), dbg_state, (exp_id == REQ_D) ? D_GNT : I_GNT);
      check($sformatf("cont%0d_addr", t), mem_addr, (exp_id == REQ_D) ? D_ADDR : 28'h200);
      @(negedge clk); mem_ready = 1'b1; #1;
      check($sformatf("cont%0d_i_ready", t), i_mem_ready, exp_id == REQ_I);
      check($sformatf("cont%0d_d_ready", t), d_mem_ready, exp_id == REQ_D);
      @(negedge clk); mem_ready = 1'b0; #1;
      check($sformatf("cont%0d_gap", t), dbg_state, IDLE);
      check($sformatf("cont%0d_gap_rd", t), mem_read, 1'b0);
      exp_id = ~exp_id;
    end
    check("cont_cnt_i", cnt_i_grant, 5);
    check("cont_cnt_d", cnt_d_grant, 5);
    check("cont_cnt_c", cnt_conflict, 20);

    // saturation: 20 icache transactions against the 4-bit counter instance
    @(negedge clk);
    proc_reset_n = 1'b0; i_mem_read = 1'b0; d_mem_read = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    proc_reset_n = 1'b1;
    #1;
    check("sat_reset_cnt", s_cnt_i, 4'd0);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk); i_mem_read = 1'b1; i_mem_addr = 28'h40;
      @(negedge clk); mem_ready = 1'b1; #1;
      check($sformatf("sat%0d_i_ready", n), i_mem_ready, 1'b1);
      @(negedge clk); i_mem_read = 1'b0; mem_ready = 1'b0; #1;
      if (n == 15) check("sat_at_15", s_cnt_i, 4'd15);
    end
    check("sat_wide_cnt_i", cnt_i_grant, 20);
    check("sat_narrow_cnt_i", s_cnt_i, 4'd15);
    check("sat_narrow_cnt_d", s_cnt_d, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 128-bit line-wide memory port between the read-only instruction cache and the read/write data cache.
- Accepts level-held line requests from both caches and grants one requester at a time.
- While a requester holds the grant, the arbiter steers that requester's request onto the memory bus and returns mem_ready only to that requester.
- Sits between the two cache instances and the memory model/controller in the pipeline top level.

Parameters:
ADDR_W, 28, line address width (byte address bits [31:4])
LINE_W, 128, line data width
D_FIRST, 1, priority tie-break after reset: 1 = data cache wins the first conflict, 0 = instruction cache wins
CNT_W, 32, width of the saturating performance counters

Ports:
clk  in  1  system clock, rising edge
proc_reset_n  in  1  synchronous active-low reset
i_mem_read  in  1  icache line read request, held until i_mem_ready
i_mem_addr  in  ADDR_W  icache line address
i_mem_rdata  out  LINE_W  read data to icache
i_mem_ready  out  1  one-cycle completion pulse to icache
d_mem_read  in  1  dcache line read request, held until d_mem_ready
d_mem_write  in  1  dcache line write-back request, held until d_mem_ready
d_mem_addr  in  ADDR_W  dcache line address
d_mem_wdata  in  LINE_W  dcache write-back data
d_mem_rdata  out  LINE_W  read data to dcache
d_mem_ready  out  1  one-cycle completion pulse to dcache
mem_read  out  1  to memory
mem_write  out  1  to memory
mem_addr  out  ADDR_W  to memory
mem_wdata  out  LINE_W  to memory
mem_rdata  in  LINE_W  from memory
mem_ready  in  1  one-cycle completion pulse from memory
cnt_i_grant  out  CNT_W  number of icache grants
cnt_d_grant  out  CNT_W  number of dcache grants
cnt_conflict  out  CNT_W  cycles where one cache waits while the other holds the grant

Behaviour:
- Reset is synchronous active-low: clk and proc_reset_n, sampled on the rising edge.
- Reset values: state IDLE; rr_last = D_FIRST ? I : D; all counters 0.
- Reset values of outputs: mem_read = mem_write = 0, mem_addr = 0, mem_wdata = 0, both *_ready = 0.
- A reset while a request is in flight abandons it. The memory model is reset with the same signal.
- A request is any of i_mem_read, d_mem_read or d_mem_write. d_mem_read together with d_mem_write is illegal; the bench asserts on it.
- State IDLE: all mem_* outputs are 0 and mem_ready is ignored.
  - Only one cache requesting: go to that cache's GRANT state (I_GNT or D_GNT).
  - Both requesting: grant the cache that is not rr_last.
  - On every grant: rr_last <= winner and the winner's grant counter increments.
- State I_GNT: mem_read = i_mem_read, mem_write = 0, mem_addr = i_mem_addr, mem_wdata = 0.
- State D_GNT: mem_read = d_mem_read, mem_write = d_mem_write, mem_addr = d_mem_addr, mem_wdata = d_mem_wdata.
- Outputs are a combinational mux driven from the registered state. No bus output depends combinationally on any request input except through the granted channel.
- In a GRANT state, when mem_ready = 1:
  - the granted *_ready = mem_ready in the same cycle;
  - the granted *_rdata = mem_rdata;
  - next state is IDLE.
- Ungranted side: *_ready = 0. Both *_rdata outputs always carry mem_rdata, and the caches qualify them with ready.
- Abort: in a GRANT state, if the granted request drops without mem_ready, go to IDLE next cycle. No ready pulse is issued and the grant count is kept.
- Minimum spacing: a request raised in cycle t reaches memory in cycle t+1. After a ready pulse the bus is idle for at least one cycle.
- Back-to-back: after a completion, a still-pending request from the other cache wins IDLE next, because the round-robin pointer favours it. The same cache cannot win twice in a row while the other waits.
- cnt_conflict increments in every GRANT cycle in which the other cache's request is high.
- All counters saturate at 2^CNT_W-1 and do not wrap.
- Grant is exclusive: i_mem_ready and d_mem_ready are never high together. mem_read and mem_write are never high together.

Decomposition:
- Shared package holds:
  - state encoding localparams IDLE = 2'b00, I_GNT = 2'b01, D_GNT = 2'b10;
  - requester-ID constants REQ_I = 1'b0, REQ_D = 1'b1.
- One natural sub-module: sat_counter, a CNT_W-bit saturating incrementer with synchronous active-low clear, instantiated three times.

Test Plan:
- icache only: i_mem_read with addr 28'h0000040, memory ready after 3 cycles -> mem_read high from cycle t+1 with mem_addr 0x0000040; i_mem_ready pulses once carrying mem_rdata; d_mem_ready stays 0; cnt_i_grant = 1.
- Simultaneous after reset with D_FIRST = 1: dcache write to 0x0000100 and icache read to 0x0000200 raised in the same cycle -> dcache wins with mem_write = 1 and mem_wdata forwarded.
  - After the ready pulse, 1 idle cycle follows, then the icache is granted.
  - cnt_conflict equals the dcache grant length; both grant counters = 1.
- Continuous contention, both held high for 10 transactions -> grants strictly alternate I/D and no two consecutive grants go to the same cache.
- Abort: icache granted, i_mem_read drops before mem_ready -> state returns to IDLE next cycle, no i_mem_ready, and a pending dcache request is granted one cycle later.
- Reset mid-transfer: proc_reset_n = 0 during D_GNT -> on the next edge all outputs are 0, state is IDLE and counters are 0; a mem_ready arriving in the reset cycle produces no *_ready.
- Saturation with CNT_W = 4: 20 icache transactions -> cnt_i_grant holds at 15.
